key_expansion: RTL and testbench
================================

KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock, all state rising-edge.
REQ-002 The block SHALL have the port i_Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port i_Start, input, 1 bit: begin expansion of i_Key (sampled in IDLE only).
REQ-004 The block SHALL have the port i_Key, input, 128 bits: AES-128 cipher key, word w0 = bits [127:96].
REQ-005 The block SHALL have the port o_Round_Key, output, 128 bits: current round key, fed to round stages and the final round stage.
REQ-006 The block SHALL have the port o_Round_Num, output, 4 bits: index 0..10 of o_Round_Key.
REQ-007 The block SHALL have the port o_Key_Valid, output, 1 bit: o_Round_Key/o_Round_Num valid.
REQ-008 The block SHALL have the port i_Key_Ready, input, 1 bit: consumer accepts the key; a handshake occurs when o_Key_Valid and i_Key_Ready are both high on a clock edge.
REQ-009 The block SHALL have the port o_Busy, output, 1 bit: high from start acceptance until the round-10 handshake.

Function
REQ-010 The FSM SHALL have the states IDLE, GEN (next key being computed; pipelined build only) and PRESENT (key valid, awaiting handshake).
REQ-011 In IDLE with i_Start=1, the block SHALL register i_Key as round 0, set o_Round_Num=0 and o_Busy=1, and enter PRESENT; o_Key_Valid SHALL rise the next cycle.
REQ-012 In IDLE, i_Start=0 SHALL hold all outputs unchanged, with o_Key_Valid=0.
REQ-013 i_Start SHALL be ignored while o_Busy=1; i_Key is sampled only on start acceptance.
REQ-014 In PRESENT, o_Round_Key and o_Round_Num SHALL remain stable while o_Key_Valid=1 and i_Key_Ready=0.
REQ-015 On a handshake at round r<10, the block SHALL compute the next key: t = SubWord(RotWord(w3)) XOR {Rcon[r+1],24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-016 The Rcon sequence for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-017 SubWord SHALL apply the FIPS-197 S-box to each of the 4 bytes independently, using 4 S-box instances.
REQ-018 A handshake at round 10 SHALL return the FSM to IDLE with o_Key_Valid=0 and o_Busy=0 on the same edge; o_Round_Key and o_Round_Num SHALL retain the round-10 values.
REQ-019 i_Start SHALL be accepted on the cycle after the round-10 handshake (back-to-back keys).
REQ-020 o_Round_Num SHALL never exceed 10 and SHALL never wrap.

Reset
REQ-021 Assertion of i_Reset_n=0 SHALL immediately force IDLE, o_Round_Key=0, o_Round_Num=0, o_Key_Valid=0 and o_Busy=0, regardless of clock.
REQ-022 Reset mid-expansion SHALL abandon the expansion; there SHALL be no partial key output after release.
REQ-023 After reset release, the first i_Start SHALL behave per REQ-011.

Configuration
REQ-024 Macro KEY_EXP_SBOX_PIPE_EN: when undefined, the next key SHALL be loaded on the handshake edge and o_Key_Valid SHALL stay high, giving 1 key per cycle with i_Key_Ready held high (11 cycles rounds 0..10).
REQ-025 When KEY_EXP_SBOX_PIPE_EN is defined, the SubWord output SHALL be registered: a handshake at r<10 SHALL enter GEN and drop o_Key_Valid for exactly one cycle, then present round r+1 (2 cycles per key after round 0).
REQ-026 Key values, Rcon, reset behaviour and round-10 termination SHALL be identical in both builds.

Verification
REQ-027 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, i_Key_Ready=1 -> round 1 = a0fafe1788542cb123a339392a6c7605 and round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; o_Busy=0 after round 10.
REQ-028 Same key, i_Key_Ready low for 5 cycles at round 3 -> o_Round_Key/o_Round_Num=3 stable for all 5 cycles, with no skipped or repeated round.
REQ-029 i_Start pulsed with a different key at round 4 -> ignored; the sequence completes with the original key values.
REQ-030 i_Reset_n low at round 6 -> all outputs 0 within the same cycle; a new start with key 000102…0f yields round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-031 Pipelined build, i_Key_Ready=1 -> o_Key_Valid pattern 1,0,1,0,… with exactly 11 valid cycles; key values match REQ-027.
REQ-032 Round-10 handshake and i_Start high on the next cycle -> new expansion starts, round 0 presented one cycle later.

Source files
------------

// File: rtl/key_expansion_if.sv
// ============================================================================
// key_expansion_if : start/key input and round-key handshake bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface key_expansion_if;
    logic         i_Start;
    logic [127:0] i_Key;
    logic [127:0] o_Round_Key;
    logic [3:0]   o_Round_Num;
    logic         o_Key_Valid;
    logic         i_Key_Ready;
    logic         o_Busy;

    modport master (
        output i_Start, i_Key, i_Key_Ready,
        input  o_Round_Key, o_Round_Num, o_Key_Valid, o_Busy
    );

    modport slave (
        input  i_Start, i_Key, i_Key_Ready,
        output o_Round_Key, o_Round_Num, o_Key_Valid, o_Busy
    );
endinterface

`default_nettype wire

// File: rtl/key_expansion.sv
// ============================================================================
// key_expansion : AES-128 round-key generator, one key per handshake.
// Optional KEY_EXP_SBOX_PIPE_EN registers SubWord (one GEN cycle per round).
// Revision 1.0
// ============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_idx;

    assign bit_idx  = {in_byte, 3'b000};
    assign out_byte = SBOX_TABLE[11'd2047 - bit_idx -: 8];
endmodule

module key_expansion (
    input  logic           clk,
    input  logic           i_Reset_n,
    key_expansion_if.slave kif
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GEN     = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         handshake;
    logic         last_round;
    logic         load_start;
    logic         load_next;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  sub_src;
    logic [31:0]  temp;
    logic [7:0]   rcon;
    logic [31:0]  w0_next;
    logic [31:0]  w1_next;
    logic [31:0]  w2_next;
    logic [31:0]  w3_next;

    assign handshake  = (state == PRESENT) && kif.i_Key_Ready;
    assign last_round = (round_num == 4'd10);
    assign rot_word   = {round_key[23:0], round_key[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*i +: 8]),
            .out_byte (sub_word[8*i +: 8])
        );
    end

`ifdef KEY_EXP_SBOX_PIPE_EN
    logic [31:0] sub_q;

    always_ff @(posedge clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sub_q <= '0;
        end else if (handshake && !last_round) begin
            sub_q <= sub_word;
        end
    end

    assign sub_src = sub_q;
`else
    assign sub_src = sub_word;
`endif

    // Rcon for the round being generated (round_num + 1).
    always_comb begin
        rcon = 8'h00;
        case (round_num)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign temp    = sub_src ^ {rcon, 24'h000000};
    assign w0_next = round_key[127:96] ^ temp;
    assign w1_next = round_key[95:64]  ^ w0_next;
    assign w2_next = round_key[63:32]  ^ w1_next;
    assign w3_next = round_key[31:0]   ^ w2_next;

    always_ff @(posedge clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_start = 1'b0;
        load_next  = 1'b0;
        case (state)
            IDLE: begin
                if (kif.i_Start) begin
                    load_start = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    if (last_round) begin
                        state_next = IDLE;
                    end else begin
`ifdef KEY_EXP_SBOX_PIPE_EN
                        state_next = GEN;
`else
                        load_next  = 1'b1;
`endif
                    end
                end
            end
            GEN: begin
                load_next  = 1'b1;
                state_next = PRESENT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            round_key <= '0;
            round_num <= '0;
        end else if (load_start) begin
            round_key <= kif.i_Key;
            round_num <= 4'd0;
        end else if (load_next) begin
            round_key <= {w0_next, w1_next, w2_next, w3_next};
            round_num <= round_num + 4'd1;
        end
    end

    assign kif.o_Round_Key = round_key;
    assign kif.o_Round_Num = round_num;
    assign kif.o_Key_Valid = (state == PRESENT);
    assign kif.o_Busy      = (state != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_key_expansion.sv
// ============================================================================
// tb_key_expansion : scoreboard bench for key_expansion (either build)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_key_expansion;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_expansion_if kif ();

    key_expansion dut (
        .clk       (clk),
        .i_Reset_n (rst_n),
        .kif       (kif)
    );

    typedef struct {
        logic [3:0]   num;
        logic [127:0] key;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] cand;
        for (int c = 1; c < 256; c++) begin
            cand = 8'(c);
            if (a != 8'h00 && gmul(a, cand) == 8'h01) inv = cand;
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic push_expected(input logic [127:0] key);
        logic [31:0] w[4];
        logic [31:0] t;
        logic [31:0] rw;
        logic [7:0]  rc = 8'h01;
        exp_t        e;
        e.num = 4'd0;
        e.key = key;
        sb_q.push_back(e);
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        for (int r = 1; r <= 10; r++) begin
            rw = {w[3][23:0], w[3][31:24]};
            t  = {sbox_ref(rw[31:24]), sbox_ref(rw[23:16]), sbox_ref(rw[15:8]), sbox_ref(rw[7:0])};
            t  = t ^ {rc, 24'h000000};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            e.num = 4'(r);
            e.key = {w[0], w[1], w[2], w[3]};
            sb_q.push_back(e);
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    // Every handshake edge consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("num_range", 128'(kif.o_Round_Num > 4'd10), 128'(0));
                if (kif.o_Key_Valid && kif.i_Key_Ready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 128'(sb_q.size()), 128'(1));
                    end else begin
                        e = sb_q.pop_front();
                        check("round_key", kif.o_Round_Key, e.key);
                        check("round_num", 128'(kif.o_Round_Num), 128'(e.num));
                    end
                end
            end
        end
    end

    task automatic run_seq(input logic [127:0] key, input int stall_r, input int inject_r,
                           input logic [127:0] inject_key, input int reset_r,
                           input logic [127:0] r1_lit, input logic [127:0] r10_lit);
        int           base;
        int           cycles;
        int           stall;
        int           exp_cycles;
        bit           injected;
        bit           prev_hs;
        logic [3:0]   prev_num;
        logic [127:0] stall_key;
        check("idle_before_start", 128'(kif.o_Busy), 128'(0));
        base = sb_q.size();
        push_expected(key);
        stall_key = (stall_r >= 0) ? sb_q[base + stall_r].key : '0;
        kif.i_Start     = 1'b1;
        kif.i_Key       = key;
        kif.i_Key_Ready = 1'b1;
        @(posedge clk); #1;
        kif.i_Start = 1'b0;
        kif.i_Key   = ~key;
        check("start_busy",  128'(kif.o_Busy),      128'(1));
        check("start_valid", 128'(kif.o_Key_Valid), 128'(1));
        check("start_num",   128'(kif.o_Round_Num), 128'(0));
        cycles   = 1;
        stall    = 0;
        injected = 1'b0;
        prev_hs  = 1'b0;
        prev_num = 4'd0;
        for (int it = 0; it < 300; it++) begin
            if (prev_hs) begin
`ifdef KEY_EXP_SBOX_PIPE_EN
                check("gen_gap_valid", 128'(kif.o_Key_Valid), 128'(0));
`else
                check("next_round", 128'(kif.o_Round_Num), 128'(prev_num) + 128'd1);
`endif
            end
            if (!kif.o_Busy) break;
            if (reset_r >= 0 && kif.o_Key_Valid && int'(kif.o_Round_Num) == reset_r) begin
                rst_n = 1'b0;
                #1;
                check("mid_rst_key",   kif.o_Round_Key,           128'(0));
                check("mid_rst_num",   128'(kif.o_Round_Num),     128'(0));
                check("mid_rst_valid", 128'(kif.o_Key_Valid),     128'(0));
                check("mid_rst_busy",  128'(kif.o_Busy),          128'(0));
                sb_q.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                check("post_rst_valid", 128'(kif.o_Key_Valid), 128'(0));
                check("post_rst_key",   kif.o_Round_Key,       128'(0));
                return;
            end
            if (r1_lit != '0 && kif.o_Key_Valid && kif.o_Round_Num == 4'd1)
                check("round1_literal", kif.o_Round_Key, r1_lit);
            if (inject_r >= 0 && !injected && kif.o_Key_Valid && int'(kif.o_Round_Num) == inject_r) begin
                kif.i_Start = 1'b1;
                kif.i_Key   = inject_key;
                injected    = 1'b1;
            end else begin
                kif.i_Start = 1'b0;
            end
            if (stall_r >= 0 && kif.o_Key_Valid && int'(kif.o_Round_Num) == stall_r && stall < 5) begin
                kif.i_Key_Ready = 1'b0;
                check("stall_key", kif.o_Round_Key, stall_key);
                stall++;
            end else begin
                kif.i_Key_Ready = 1'b1;
            end
            prev_hs  = kif.o_Key_Valid && kif.i_Key_Ready && (kif.o_Round_Num < 4'd10);
            prev_num = kif.o_Round_Num;
            @(posedge clk); #1;
            if (kif.o_Busy) cycles++;
        end
        kif.i_Start = 1'b0;
        check("done_in_budget", 128'(kif.o_Busy), 128'(0));
`ifdef KEY_EXP_SBOX_PIPE_EN
        exp_cycles = 21;
`else
        exp_cycles = 11;
`endif
        if (stall_r >= 0) begin
            exp_cycles += 5;
            check("stall_len", 128'(stall), 128'(5));
        end
        check("busy_cycles", 128'(cycles), 128'(exp_cycles));
        check("sb_drained",  128'(sb_q.size()), 128'(0));
        check("final_num",   128'(kif.o_Round_Num), 128'(10));
        check("final_valid", 128'(kif.o_Key_Valid), 128'(0));
        if (r10_lit != '0) check("round10_literal", kif.o_Round_Key, r10_lit);
    endtask

    initial begin
        rst_n           = 1'b1;
        kif.i_Start     = 1'b0;
        kif.i_Key       = '0;
        kif.i_Key_Ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_key",   kif.o_Round_Key,       128'(0));
        check("rst_num",   128'(kif.o_Round_Num), 128'(0));
        check("rst_valid", 128'(kif.o_Key_Valid), 128'(0));
        check("rst_busy",  128'(kif.o_Busy),      128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_valid", 128'(kif.o_Key_Valid), 128'(0));

        // Straight run, then stall, then ignored restart: all back-to-back.
        run_seq(FIPS_KEY, -1, -1, '0, -1, FIPS_R1, FIPS_R10);
        run_seq(FIPS_KEY,  3, -1, '0, -1, '0, FIPS_R10);
        run_seq(FIPS_KEY, -1,  4, SEQ_KEY, -1, '0, FIPS_R10);

        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", 128'(kif.o_Key_Valid), 128'(0));
        check("hold_busy",  128'(kif.o_Busy),      128'(0));
        check("hold_key",   kif.o_Round_Key,       FIPS_R10);
        check("hold_num",   128'(kif.o_Round_Num), 128'(10));

        run_seq(FIPS_KEY, -1, -1, '0, 6, '0, '0);
        run_seq(SEQ_KEY,  -1, -1, '0, -1, '0, SEQ_R10);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
